// File: rtl/gcd_client.sv
// Request-side driver for the GCD coprocessor: issues LFSR operand pairs,
// bounds in-flight requests and checks every result against its smaller operand.
module gcd_client #(
    parameter int          W       = 32,
    parameter int          MAX_OUT = 4,
    parameter logic [W-1:0] TAPS   = 32'h80200003
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [15:0]  count,
    input  logic [W-1:0] seed,
    output logic [W-1:0] operands_bits_A,
    output logic [W-1:0] operands_bits_B,
    output logic         operands_val,
    input  logic         operands_rdy,
    input  logic [W-1:0] result_bits,
    input  logic         result_val,
    output logic         result_rdy,
    output logic         busy,
    output logic         done,
    output logic [15:0]  sent_count,
    output logic [15:0]  recv_count,
    output logic [W-1:0] checksum,
    output logic         error
);

    localparam int AW = $clog2(MAX_OUT);
    localparam int OW = AW + 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state;
    logic [15:0]   limit;
    logic [W-1:0]  lfsr;
    logic [W-1:0]  min_q [MAX_OUT];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [OW-1:0] outstanding;

    logic          op_fire;
    logic          res_fire;
    logic          res_bad;
    logic [W-1:0]  rot;
    logic [W-1:0]  lfsr_next;
    logic [W-1:0]  op_min;
    logic [W-1:0]  head;
    logic [15:0]   sent_next;
    logic [15:0]   recv_next;
    logic [OW-1:0] out_next;

    // B is a fixed rotation of the LFSR register, so both operands are flop outputs
    assign rot             = {lfsr[W/2-1:0], lfsr[W-1:W/2]};
    assign operands_bits_A = lfsr;
    assign operands_bits_B = rot;

    assign op_fire   = operands_val & operands_rdy;
    assign res_fire  = result_val & result_rdy;
    assign lfsr_next = lfsr[0] ? ((lfsr >> 1) ^ TAPS) : (lfsr >> 1);
    assign op_min    = (lfsr < rot) ? lfsr : rot;
    assign head      = min_q[rd_ptr];
    assign res_bad   = (result_bits == '0) || (result_bits > head);
    assign sent_next = sent_count + {15'd0, op_fire};
    assign recv_next = recv_count + {15'd0, res_fire};
    assign out_next  = outstanding + OW'(op_fire) - OW'(res_fire);

    always_ff @(posedge clk) begin
        if (op_fire) begin
            min_q[wr_ptr] <= op_min;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            limit        <= '0;
            lfsr         <= W'(1);
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            outstanding  <= '0;
            operands_val <= 1'b0;
            result_rdy   <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            sent_count   <= '0;
            recv_count   <= '0;
            checksum     <= '0;
            error        <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        limit       <= count;
                        lfsr        <= (seed == '0) ? W'(1) : seed;
                        wr_ptr      <= '0;
                        rd_ptr      <= '0;
                        outstanding <= '0;
                        sent_count  <= '0;
                        recv_count  <= '0;
                        checksum    <= '0;
                        error       <= 1'b0;
                        if (count == 16'd0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state        <= RUN;
                            busy         <= 1'b1;
                            operands_val <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (op_fire) begin
                        lfsr   <= lfsr_next;
                        wr_ptr <= wr_ptr + AW'(1);
                    end
                    if (res_fire) begin
                        rd_ptr   <= rd_ptr + AW'(1);
                        checksum <= checksum + result_bits;
                        if (res_bad) begin
                            error <= 1'b1;
                        end
                    end
                    sent_count  <= sent_next;
                    recv_count  <= recv_next;
                    outstanding <= out_next;
                    if (recv_next == limit) begin
                        state        <= DONE;
                        busy         <= 1'b0;
                        done         <= 1'b1;
                        operands_val <= 1'b0;
                        result_rdy   <= 1'b0;
                    end else begin
                        operands_val <= (sent_next < limit) &&
                                        (out_next < OW'(MAX_OUT));
                        result_rdy   <= (out_next != '0);
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
